memory_arbiter: RTL and testbench

Single-port arbiter that shares the unified memory between the instruction-fetch port and the load/store data port of the core. It issues one memory access per cycle, choosing data over fetch with a bounded starvation limit, and registers each response for return one cycle later. It halts all further grants after any faulting access until the trap logic clears it.

---
 rtl/memory_arbiter.sv | 157 +++++++++++++++
 tb/tb_memory_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Shares one memory port between instruction fetch and load/store data.
// Data wins contention up to STARVE_LIMIT grants; any faulting access halts grants until cleared.
//
// state | meaning
// RUN   | arbitrating, one grant per cycle
// FAULT | a faulting access was captured; no grants until i_FaultClear
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_FetchReq,
  input  logic [31:0] i_FetchAddress,
  output logic        o_FetchGrant,
  output logic        o_FetchValid,
  output logic [31:0] o_FetchData,
  output logic        o_FetchFault,
  input  logic        i_DataReq,
  input  logic        i_DataWrite,
  input  logic [31:0] i_DataAddress,
  input  logic [31:0] i_DataWriteData,
  input  logic [2:0]  i_DataMode,
  output logic        o_DataGrant,
  output logic        o_DataValid,
  output logic [31:0] o_DataReadData,
  output logic        o_DataMisaligned,
  output logic        o_DataBadInstruction,
  output logic        o_MemWriteEnable,
  output logic        o_MemReadEnable,
  output logic [31:0] o_MemAddress,
  output logic [31:0] o_MemDataIn,
  output logic [2:0]  o_MemMode,
  input  logic [31:0] i_MemDataOut,
  input  logic        i_MemMisalignedAccess,
  input  logic        i_MemBadInstruction,
  input  logic        i_FaultClear,
  output logic        o_Faulted
);

  localparam logic [2:0] LOAD_WORD = 3'b010;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t          r_State, w_NextState;
  logic [CW-1:0]   r_StarveCount, w_NextStarveCount;
  logic            w_FetchGrant, w_DataGrant, w_MemFault;

  logic            r_FetchValid, r_FetchFault;
  logic [31:0]     r_FetchData;
  logic            r_DataValid, r_DataMisaligned, r_DataBadInstruction;
  logic [31:0]     r_DataReadData;

  assign w_MemFault = i_MemMisalignedAccess | i_MemBadInstruction;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State       <= RUN;
      r_StarveCount <= '0;
    end else begin
      r_State       <= w_NextState;
      r_StarveCount <= w_NextStarveCount;
    end
  end

  // Grants are gated by reset so they drop the instant reset asserts.
  always_comb begin
    w_FetchGrant      = 1'b0;
    w_DataGrant       = 1'b0;
    w_NextState       = r_State;
    w_NextStarveCount = r_StarveCount;
    case (r_State)
      RUN: begin
        if (i_FetchReq && (!i_DataReq || r_StarveCount == LIMIT)) begin
          w_FetchGrant = i_Reset_n;
        end else if (i_DataReq) begin
          w_DataGrant = i_Reset_n;
        end
        if (w_FetchGrant || !i_FetchReq) begin
          w_NextStarveCount = '0;
        end else if (w_DataGrant && r_StarveCount != LIMIT) begin
          w_NextStarveCount = r_StarveCount + CW'(1);
        end
        if ((w_FetchGrant || w_DataGrant) && w_MemFault) begin
          w_NextState = FAULT;
        end
      end
      FAULT: begin
        if (i_FaultClear) begin
          w_NextState       = RUN;
          w_NextStarveCount = '0;
        end
      end
      default: begin
        w_NextState       = RUN;
        w_NextStarveCount = '0;
      end
    endcase
  end

  always_comb begin
    o_MemWriteEnable = 1'b0;
    o_MemReadEnable  = 1'b0;
    o_MemAddress     = '0;
    o_MemDataIn      = '0;
    o_MemMode        = '0;
    if (w_FetchGrant) begin
      o_MemReadEnable = 1'b1;
      o_MemAddress    = i_FetchAddress;
      o_MemMode       = LOAD_WORD;
    end else if (w_DataGrant) begin
      o_MemWriteEnable = i_DataWrite;
      o_MemReadEnable  = !i_DataWrite;
      o_MemAddress     = i_DataAddress;
      o_MemDataIn      = i_DataWriteData;
      o_MemMode        = i_DataMode;
    end
  end

  // Response fields only update on a grant so they hold between pulses.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_FetchValid         <= 1'b0;
      r_FetchData          <= '0;
      r_FetchFault         <= 1'b0;
      r_DataValid          <= 1'b0;
      r_DataReadData       <= '0;
      r_DataMisaligned     <= 1'b0;
      r_DataBadInstruction <= 1'b0;
    end else begin
      r_FetchValid <= w_FetchGrant;
      r_DataValid  <= w_DataGrant;
      if (w_FetchGrant) begin
        r_FetchData  <= i_MemDataOut;
        r_FetchFault <= w_MemFault;
      end
      if (w_DataGrant) begin
        r_DataReadData       <= i_DataWrite ? 32'd0 : i_MemDataOut;
        r_DataMisaligned     <= i_MemMisalignedAccess;
        r_DataBadInstruction <= i_MemBadInstruction;
      end
    end
  end

  assign o_FetchGrant         = w_FetchGrant;
  assign o_DataGrant          = w_DataGrant;
  assign o_FetchValid         = r_FetchValid;
  assign o_FetchData          = r_FetchData;
  assign o_FetchFault         = r_FetchFault;
  assign o_DataValid          = r_DataValid;
  assign o_DataReadData       = r_DataReadData;
  assign o_DataMisaligned     = r_DataMisaligned;
  assign o_DataBadInstruction = r_DataBadInstruction;
  assign o_Faulted            = (r_State == FAULT);

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: byte-array memory, per-cycle reference model checked on negedge,
// plus directed scenarios with literal expectations.
module tb_memory_arbiter;
  localparam int LIMIT = 4;

  logic        i_Clock = 1'b0;
  logic        i_Reset_n;
  logic        i_FetchReq;
  logic [31:0] i_FetchAddress;
  logic        o_FetchGrant, o_FetchValid, o_FetchFault;
  logic [31:0] o_FetchData;
  logic        i_DataReq, i_DataWrite;
  logic [31:0] i_DataAddress, i_DataWriteData;
  logic [2:0]  i_DataMode;
  logic        o_DataGrant, o_DataValid, o_DataMisaligned, o_DataBadInstruction;
  logic [31:0] o_DataReadData;
  logic        o_MemWriteEnable, o_MemReadEnable;
  logic [31:0] o_MemAddress, o_MemDataIn;
  logic [2:0]  o_MemMode;
  logic [31:0] i_MemDataOut;
  logic        i_MemMisalignedAccess, i_MemBadInstruction;
  logic        i_FaultClear;
  logic        o_Faulted;

  int checks = 0;
  int failures = 0;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n),
    .i_FetchReq(i_FetchReq), .i_FetchAddress(i_FetchAddress),
    .o_FetchGrant(o_FetchGrant), .o_FetchValid(o_FetchValid),
    .o_FetchData(o_FetchData), .o_FetchFault(o_FetchFault),
    .i_DataReq(i_DataReq), .i_DataWrite(i_DataWrite),
    .i_DataAddress(i_DataAddress), .i_DataWriteData(i_DataWriteData),
    .i_DataMode(i_DataMode), .o_DataGrant(o_DataGrant), .o_DataValid(o_DataValid),
    .o_DataReadData(o_DataReadData), .o_DataMisaligned(o_DataMisaligned),
    .o_DataBadInstruction(o_DataBadInstruction),
    .o_MemWriteEnable(o_MemWriteEnable), .o_MemReadEnable(o_MemReadEnable),
    .o_MemAddress(o_MemAddress), .o_MemDataIn(o_MemDataIn), .o_MemMode(o_MemMode),
    .i_MemDataOut(i_MemDataOut), .i_MemMisalignedAccess(i_MemMisalignedAccess),
    .i_MemBadInstruction(i_MemBadInstruction),
    .i_FaultClear(i_FaultClear), .o_Faulted(o_Faulted)
  );

  always #5 i_Clock = ~i_Clock;

  // Memory: little-endian bytes; modes 0/1/2 = byte/half/word, 4/5 = unsigned byte/half loads.
  logic [7:0] mem [0:1023];

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic        bad;
  } memRes_t;

  function automatic memRes_t memAccess(input logic [31:0] addr, input logic [2:0] mode,
                                        input logic write);
    memRes_t r;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    r = '0;
    r.bad = write ? (mode > 3'd2) : !(mode inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!r.bad)
      r.mis = ((mode == 3'd1 || mode == 3'd5) && addr[0]) || (mode == 3'd2 && addr[1:0] != 2'd0);
    if (!write && !r.bad && !r.mis) begin
      w = {mem[{addr[9:2], 2'd3}], mem[{addr[9:2], 2'd2}], mem[{addr[9:2], 2'd1}], mem[{addr[9:2], 2'd0}]};
      b = w[8*addr[1:0] +: 8];
      h = w[16*addr[1] +: 16];
      case (mode)
        3'd0: r.data = {{24{b[7]}}, b};
        3'd1: r.data = {{16{h[15]}}, h};
        3'd2: r.data = w;
        3'd4: r.data = {24'd0, b};
        default: r.data = {16'd0, h};
      endcase
    end
    return r;
  endfunction

  memRes_t memNow;
  always_comb begin
    memNow = memAccess(o_MemAddress, o_MemMode, o_MemWriteEnable);
    i_MemDataOut          = memNow.data;
    i_MemMisalignedAccess = (o_MemReadEnable || o_MemWriteEnable) ? memNow.mis : 1'b0;
    i_MemBadInstruction   = (o_MemReadEnable || o_MemWriteEnable) ? memNow.bad : 1'b0;
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[256] = 8'hEF; mem[257] = 8'hBE; mem[258] = 8'hAD; mem[259] = 8'hDE;
    forever begin
      @(posedge i_Clock);
      if (o_MemWriteEnable && !i_MemMisalignedAccess && !i_MemBadInstruction) begin
        case (o_MemMode)
          3'd0: mem[o_MemAddress[9:0]] <= o_MemDataIn[7:0];
          3'd1: begin
            mem[o_MemAddress[9:0]]         <= o_MemDataIn[7:0];
            mem[o_MemAddress[9:0] + 10'd1] <= o_MemDataIn[15:8];
          end
          default: begin
            mem[o_MemAddress[9:0]]         <= o_MemDataIn[7:0];
            mem[o_MemAddress[9:0] + 10'd1] <= o_MemDataIn[15:8];
            mem[o_MemAddress[9:0] + 10'd2] <= o_MemDataIn[23:16];
            mem[o_MemAddress[9:0] + 10'd3] <= o_MemDataIn[31:24];
          end
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: fault flag, count of data wins over a waiting fetch, predicted responses.
  bit          mFaulted = 0;
  int          mStarve = 0;
  bit          pFetchValid = 0, pDataValid = 0;
  logic [31:0] hFetchData = '0, hDataRead = '0;
  logic        hFetchFault = 0, hDataMis = 0, hDataBad = 0;

  always @(negedge i_Clock) begin
    bit eF, eD;
    memRes_t r;
    logic [31:0] eAddr;
    logic [2:0]  eMode;
    if (!i_Reset_n) begin
      check("rst_fgrant", o_FetchGrant, 0);
      check("rst_dgrant", o_DataGrant, 0);
      check("rst_fvalid", o_FetchValid, 0);
      check("rst_dvalid", o_DataValid, 0);
      check("rst_faulted", o_Faulted, 0);
      check("rst_we", o_MemWriteEnable, 0);
      check("rst_re", o_MemReadEnable, 0);
      check("rst_addr", o_MemAddress, 0);
      check("rst_din", o_MemDataIn, 0);
      check("rst_fdata", o_FetchData, 0);
      check("rst_dread", o_DataReadData, 0);
      check("rst_flags", {o_FetchFault, o_DataMisaligned, o_DataBadInstruction}, 0);
      mFaulted = 0; mStarve = 0; pFetchValid = 0; pDataValid = 0;
      hFetchData = '0; hDataRead = '0; hFetchFault = 0; hDataMis = 0; hDataBad = 0;
    end else begin
      check("m_fvalid", o_FetchValid, pFetchValid);
      check("m_dvalid", o_DataValid, pDataValid);
      check("m_fdata", o_FetchData, hFetchData);
      check("m_ffault", o_FetchFault, hFetchFault);
      check("m_dread", o_DataReadData, hDataRead);
      check("m_dmis", o_DataMisaligned, hDataMis);
      check("m_dbad", o_DataBadInstruction, hDataBad);
      check("m_faulted", o_Faulted, mFaulted);

      eF = 0; eD = 0;
      if (!mFaulted) begin
        if (i_FetchReq && i_DataReq) begin
          if (mStarve == LIMIT) eF = 1; else eD = 1;
        end else begin
          eF = i_FetchReq;
          eD = i_DataReq;
        end
      end
      check("m_fgrant", o_FetchGrant, eF);
      check("m_dgrant", o_DataGrant, eD);

      eAddr = eF ? i_FetchAddress : (eD ? i_DataAddress : 32'd0);
      eMode = eF ? 3'd2 : (eD ? i_DataMode : 3'd0);
      check("m_we", o_MemWriteEnable, eD && i_DataWrite);
      check("m_re", o_MemReadEnable, eF || (eD && !i_DataWrite));
      check("m_addr", o_MemAddress, eAddr);
      check("m_mode", o_MemMode, eMode);
      if (!eF) check("m_din", o_MemDataIn, eD ? i_DataWriteData : 32'd0);

      r = memAccess(eAddr, eMode, eD && i_DataWrite);
      pFetchValid = eF;
      pDataValid  = eD;
      if (eF) begin
        hFetchData  = r.data;
        hFetchFault = r.mis | r.bad;
      end
      if (eD) begin
        hDataRead = i_DataWrite ? 32'd0 : r.data;
        hDataMis  = r.mis;
        hDataBad  = r.bad;
      end
      if (mFaulted) begin
        if (i_FaultClear) begin
          mFaulted = 0;
          mStarve  = 0;
        end
      end else begin
        if (eF || !i_FetchReq) mStarve = 0;
        else if (eD) mStarve = (mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1;
        if ((eF || eD) && (r.mis || r.bad)) mFaulted = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic setData(input logic req, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] mode);
    i_DataReq = req; i_DataWrite = wr; i_DataAddress = addr;
    i_DataWriteData = wdata; i_DataMode = mode;
  endtask

  initial begin
    string seq;
    byte   got;
    seq = "DDDDFDDDDF";
    i_Reset_n = 1'b0;
    i_FetchReq = 1'b0; i_FetchAddress = '0; i_FaultClear = 1'b0;
    setData(0, 0, 0, 0, 0);

    // Reset holds grants low even with a request present.
    cyc(); i_FetchReq = 1; i_FetchAddress = 32'h100;
    #2 check("rst_req_grant", o_FetchGrant, 0);
    cyc(); i_FetchReq = 0; i_Reset_n = 1'b1;
    #2 check("post_rst_faulted", o_Faulted, 0);

    // Single fetch
    cyc(); i_FetchReq = 1; i_FetchAddress = 32'h100;
    #2 check("fetch_grant", o_FetchGrant, 1);
    check("fetch_memaddr", o_MemAddress, 32'h100);
    check("fetch_memmode", o_MemMode, 3'd2);
    cyc(); i_FetchReq = 0;
    #2 check("fetch_valid", o_FetchValid, 1);
    check("fetch_data", o_FetchData, 32'hDEADBEEF);
    check("fetch_fault", o_FetchFault, 0);

    // Contention
    cyc(); i_FetchReq = 1; i_FetchAddress = 32'h10;
    setData(1, 0, 32'h20, 0, 3'd2);
    for (int i = 0; i < 10; i++) begin
      #2;
      got = (o_FetchGrant && !o_DataGrant) ? "F" : ((o_DataGrant && !o_FetchGrant) ? "D" : "-");
      check($sformatf("contend_%0d", i), 32'(got), 32'(seq[i]));
      cyc();
    end

    // Store byte then load byte unsigned
    i_FetchReq = 0;
    setData(1, 1, 32'h203, 32'h000000A5, 3'd0);
    #2 check("store_grant", o_DataGrant, 1);
    check("store_we", o_MemWriteEnable, 1);
    cyc(); setData(1, 0, 32'h203, 0, 3'd4);
    #2 check("store_valid", o_DataValid, 1);
    check("store_rdata", o_DataReadData, 0);
    cyc(); setData(0, 0, 0, 0, 0);
    #2 check("load_valid", o_DataValid, 1);
    check("load_rdata", o_DataReadData, 32'h000000A5);

    // Misaligned load, fetch held during FAULT
    cyc(); setData(1, 0, 32'h202, 0, 3'd2);
    #2 check("mis_grant", o_DataGrant, 1);
    cyc(); setData(0, 0, 0, 0, 0); i_FetchReq = 1; i_FetchAddress = 32'h100;
    #2 check("mis_flag", o_DataMisaligned, 1);
    check("mis_valid", o_DataValid, 1);
    check("mis_faulted", o_Faulted, 1);
    check("mis_fgrant", o_FetchGrant, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #2 check($sformatf("fault_idle_%0d", i), o_FetchGrant, 0);
    end
    cyc(); i_FaultClear = 1;
    #2 check("clear_cycle_grant", o_FetchGrant, 0);
    cyc(); i_FaultClear = 0;
    #2 check("after_clear_faulted", o_Faulted, 0);
    check("after_clear_fgrant", o_FetchGrant, 1);
    cyc(); i_FetchReq = 0;
    #2 check("after_clear_fdata", o_FetchData, 32'hDEADBEEF);

    // Fetch fault, then FaultClear ignored in RUN
    cyc(); i_FetchReq = 1; i_FetchAddress = 32'h102;
    #2 check("ffault_grant", o_FetchGrant, 1);
    cyc(); i_FetchReq = 0;
    #2 check("ffault_flag", o_FetchFault, 1);
    check("ffault_faulted", o_Faulted, 1);
    cyc(); i_FaultClear = 1;
    cyc(); setData(1, 0, 32'h100, 0, 3'd2);
    #2 check("run_clear_faulted", o_Faulted, 0);
    check("run_clear_dgrant", o_DataGrant, 1);
    cyc(); setData(0, 0, 0, 0, 0);
    #2 check("run_clear_faulted2", o_Faulted, 0);
    check("run_clear_dread", o_DataReadData, 32'hDEADBEEF);
    cyc(); i_FaultClear = 0;

    // Reset during a data grant
    cyc(); setData(1, 0, 32'h100, 0, 3'd2);
    #2 check("rmid_grant", o_DataGrant, 1);
    i_Reset_n = 1'b0;
    #1 check("rmid_dgrant", o_DataGrant, 0);
    check("rmid_re", o_MemReadEnable, 0);
    check("rmid_addr", o_MemAddress, 0);
    check("rmid_dread", o_DataReadData, 0);
    cyc(); setData(0, 0, 0, 0, 0);
    cyc(); i_Reset_n = 1'b1;
    #2 check("rmid_no_valid", o_DataValid, 0);
    cyc(); i_FetchReq = 1; i_FetchAddress = 32'h104;
    #2 check("rmid_first_grant", o_FetchGrant, 1);
    cyc(); i_FetchReq = 0;
    #2 check("rmid_first_valid", o_FetchValid, 1);
    check("rmid_first_data", o_FetchData, 32'h5D5C5F5E);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
